scanline_buffer: RTL and testbench

SCANLINE_BUFFER -- requirements
Module: scanline_buffer

---
 rtl/scanline_buffer.sv | 99 +++++++++
 tb/tb_scanline_buffer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/scanline_buffer.sv
// Double-buffered NES scanline store: PPU fills one bank while VGA reads the other.
// Latency: vga_buf_out is registered, valid one clk after vga_buf_idx.
// Backpressure: none; writes during W_HOLD are dropped, VGA requests without a line repeat the old one.
// Optional feature: define SCANLINE_BUFFER_STATS_EN to implement underrun/overrun counters.
module scanline_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        ppu_pix_we,
    input  logic [7:0]  ppu_pix_idx,
    input  logic [5:0]  ppu_pix_data,
    input  logic        ppu_line_done,
    input  logic        vga_line_req,
    input  logic [7:0]  vga_buf_idx,
    output logic [5:0]  vga_buf_out,
    output logic        line_ready,
    output logic [15:0] underrun_cnt,
    output logic [15:0] overrun_cnt
);

    localparam logic [0:0] W_FILL = 1'b0;
    localparam logic [0:0] W_HOLD = 1'b1;

    logic [0:0] r_state;
    logic       r_rd_bank;
    // Both banks live in one array; the bank bit is the address MSB.
    logic [5:0] r_mem [0:511];

    logic w_wr_bank;
    logic w_wr_en;
    logic w_swap;

    // The write bank is by construction the bank not being read.
    assign w_wr_bank = ~r_rd_bank;
    assign w_wr_en   = (r_state == W_FILL) && ppu_pix_we && !rst;
    // A line completing in the same cycle as the request is swapped in directly.
    assign w_swap    = vga_line_req && ((r_state == W_HOLD) || ppu_line_done);
    assign line_ready = (r_state == W_HOLD);

    // Write FSM and bank selection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= W_FILL;
            r_rd_bank <= 1'b0;
        end else if (w_swap) begin
            r_state   <= W_FILL;
            r_rd_bank <= w_wr_bank;
        end else if ((r_state == W_FILL) && ppu_line_done) begin
            r_state   <= W_HOLD;
        end
    end

    // Pixel write into the fill bank; contents are never cleared.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[{w_wr_bank, ppu_pix_idx}] <= ppu_pix_data;
        end
    end

    // Registered read from the display bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            vga_buf_out <= 6'h00;
        end else begin
            vga_buf_out <= r_mem[{r_rd_bank, vga_buf_idx}];
        end
    end

`ifdef SCANLINE_BUFFER_STATS_EN
    logic [15:0] r_underrun_cnt;
    logic [15:0] r_overrun_cnt;
    logic        w_underrun;
    logic        w_overrun;

    assign w_underrun = vga_line_req && (r_state == W_FILL) && !ppu_line_done;
    assign w_overrun  = ppu_line_done && (r_state == W_HOLD);

    // Saturating event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_underrun_cnt <= 16'h0000;
            r_overrun_cnt  <= 16'h0000;
        end else begin
            if (w_underrun && (r_underrun_cnt != 16'hFFFF)) begin
                r_underrun_cnt <= r_underrun_cnt + 16'h0001;
            end
            if (w_overrun && (r_overrun_cnt != 16'hFFFF)) begin
                r_overrun_cnt <= r_overrun_cnt + 16'h0001;
            end
        end
    end

    assign underrun_cnt = r_underrun_cnt;
    assign overrun_cnt  = r_overrun_cnt;
`else
    assign underrun_cnt = 16'h0000;
    assign overrun_cnt  = 16'h0000;
`endif

endmodule

// File: tb/tb_scanline_buffer.sv
// Bench for scanline_buffer: line-level model plus directed scenarios.
// Works with or without SCANLINE_BUFFER_STATS_EN defined.
module tb_scanline_buffer;

`ifdef SCANLINE_BUFFER_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ppu_pix_we = 1'b0;
    logic [7:0]  ppu_pix_idx = 8'h00;
    logic [5:0]  ppu_pix_data = 6'h00;
    logic        ppu_line_done = 1'b0;
    logic        vga_line_req = 1'b0;
    logic [7:0]  vga_buf_idx = 8'h00;
    logic [5:0]  vga_buf_out;
    logic        line_ready;
    logic [15:0] underrun_cnt;
    logic [15:0] overrun_cnt;

    int tests = 0;
    int fails = 0;

    scanline_buffer dut (
        .clk          (clk),
        .rst          (rst),
        .ppu_pix_we   (ppu_pix_we),
        .ppu_pix_idx  (ppu_pix_idx),
        .ppu_pix_data (ppu_pix_data),
        .ppu_line_done(ppu_line_done),
        .vga_line_req (vga_line_req),
        .vga_buf_idx  (vga_buf_idx),
        .vga_buf_out  (vga_buf_out),
        .line_ready   (line_ready),
        .underrun_cnt (underrun_cnt),
        .overrun_cnt  (overrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: two line stores, "shown" is the displayed one, the other collects
    // the PPU line; "pending" means a full line waits for the next VGA request.
    logic [5:0] m_line [2][256];
    bit         m_known [2][256];
    int         m_shown;
    bit         m_pending;
    int         m_under;
    int         m_over;
    int         m_out;
    bit         m_out_known;
    bit         m_started = 1'b0;

    always @(posedge clk) begin
        m_started = 1'b1;
        if (rst) begin
            m_shown = 0; m_pending = 0; m_under = 0; m_over = 0;
            m_out = 0; m_out_known = 1;
            for (int b = 0; b < 2; b++)
                for (int i = 0; i < 256; i++) m_known[b][i] = 0;
        end else begin
            m_out       = m_line[m_shown][vga_buf_idx];
            m_out_known = m_known[m_shown][vga_buf_idx];
            if (!m_pending && ppu_pix_we) begin
                m_line[1 - m_shown][ppu_pix_idx]  = ppu_pix_data;
                m_known[1 - m_shown][ppu_pix_idx] = 1;
            end
            if (vga_line_req && !m_pending && !ppu_line_done && m_under < 65535) m_under++;
            if (ppu_line_done && m_pending && m_over < 65535) m_over++;
            if (vga_line_req && (m_pending || ppu_line_done)) begin
                m_shown   = 1 - m_shown;
                m_pending = 0;
            end else if (ppu_line_done) begin
                m_pending = 1;
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            chk("line_ready", line_ready, m_pending);
            chk("underrun_cnt", underrun_cnt, m_under * STATS);
            chk("overrun_cnt", overrun_cnt, m_over * STATS);
            if (m_out_known) chk("vga_buf_out", vga_buf_out, m_out);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int idx, input logic [5:0] d);
        ppu_pix_we = 1'b1; ppu_pix_idx = idx[7:0]; ppu_pix_data = d;
        vga_buf_idx = 8'(255 - idx);
        tick();
        ppu_pix_we = 1'b0;
    endtask

    task automatic fill(input int lo, input int hi, input logic [5:0] d, input bit ramp);
        for (int i = lo; i <= hi; i++) begin
            logic [7:0] iv;
            iv = i[7:0];
            put(i, ramp ? iv[5:0] : d);
        end
    endtask

    task automatic pulse(input bit done, input bit req);
        ppu_line_done = done; vga_line_req = req;
        tick();
        ppu_line_done = 1'b0; vga_line_req = 1'b0;
    endtask

    task automatic rd(input string name, input int idx, input int exp);
        vga_buf_idx = idx[7:0];
        tick();
        chk(name, vga_buf_out, exp);
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        tick(); tick(); tick();
        chk("rst_line_ready", line_ready, 0);
        chk("rst_out", vga_buf_out, 6'h00);
        chk("rst_under", underrun_cnt, 0);
        chk("rst_over", overrun_cnt, 0);
        rst = 1'b0;

        // Ramp line into bank 1, complete, swap, read back
        fill(0, 255, 6'h00, 1'b1);
        pulse(1'b1, 1'b0);
        chk("ramp_ready", line_ready, 1);
        pulse(1'b0, 1'b1);
        chk("ramp_swapped", line_ready, 0);
        rd("ramp_idx0", 0, 6'h00);
        rd("ramp_idx37", 37, 6'h25);
        rd("ramp_idx255", 255, 6'h3F);

        // Line A, then a second request with no new line repeats it
        fill(0, 255, 6'h11, 1'b0);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        rd("lineA_row1", 7, 6'h11);
        pulse(1'b0, 1'b1);
        rd("lineA_row2", 7, 6'h11);
        chk("underrun_1", underrun_cnt, STATS);

        // Writes and line_done while holding
        fill(0, 255, 6'h15, 1'b0);
        pulse(1'b1, 1'b0);
        put(5, 6'h2A);
        pulse(1'b1, 1'b0);
        chk("overrun_1", overrun_cnt, STATS);
        chk("hold_ready", line_ready, 1);
        pulse(1'b0, 1'b1);
        rd("hold_idx5", 5, 6'h15);

        // Last write, line_done and request in the same cycle
        fill(0, 254, 6'h07, 1'b0);
        ppu_pix_we = 1'b1; ppu_pix_idx = 8'd255; ppu_pix_data = 6'h30;
        ppu_line_done = 1'b1; vga_line_req = 1'b1;
        tick();
        ppu_pix_we = 1'b0; ppu_line_done = 1'b0; vga_line_req = 1'b0;
        chk("same_ready", line_ready, 0);
        chk("same_under", underrun_cnt, STATS);
        rd("same_idx255", 255, 6'h30);
        rd("same_idx0", 0, 6'h07);

        // Reset mid-fill, then refill bank 1
        fill(0, 100, 6'h3C, 1'b0);
        rst = 1'b1;
        tick();
        chk("mid_rst_ready", line_ready, 0);
        chk("mid_rst_out", vga_buf_out, 6'h00);
        chk("mid_rst_under", underrun_cnt, 0);
        chk("mid_rst_over", overrun_cnt, 0);
        tick();
        rst = 1'b0;
        fill(0, 255, 6'h09, 1'b0);
        pulse(1'b1, 1'b1);
        rd("refill_idx50", 50, 6'h09);
        rd("refill_idx200", 200, 6'h09);
        chk("refill_under", underrun_cnt, 0);

        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
